// File: rtl/l2_temp_pingpong_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | l2_temp_pingpong_ctrl_pkg : bank states and sizing defaults for the       |
// | layer-2 temp ping-pong banks.             Revision 1.0                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package l2_temp_pingpong_ctrl_pkg;

  localparam int DEPTH_DEFAULT = 64;
  localparam int AW_DEFAULT    = 6;

  typedef logic [2:0] bank_state_t;

  // ST_INIT only exists between reset release and the first clear.
  localparam logic [2:0] ST_EMPTY = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_FULL  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_CLR   = 3'd4;
  localparam logic [2:0] ST_INIT  = 3'd5;

endpackage

`default_nettype wire

// File: rtl/l2_temp_pingpong_ctrl_bank_fsm.sv
// +----------------------------------------------------------------------------+
// | temp_bank_fsm : lifecycle of one temp bank, owns its clear strobe.        |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module temp_bank_fsm
  import l2_temp_pingpong_ctrl_pkg::*;
#(
  parameter int CLEAR_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        fill_start_i,
  input  logic        fill_done_i,
  input  logic        drain_start_i,
  input  logic        drain_done_i,
  output bank_state_t state_o,
  output logic        clear_o
);

  localparam int            CW       = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);

  bank_state_t   state_q, state_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_INIT: begin
        state_d   = ST_CLR;
        clr_cnt_d = '0;
      end
      ST_EMPTY: if (fill_start_i)  state_d = ST_FILL;
      ST_FILL:  if (fill_done_i)   state_d = ST_FULL;
      ST_FULL:  if (drain_start_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (drain_done_i) begin
          state_d   = ST_CLR;
          clr_cnt_d = '0;
        end
      end
      ST_CLR: begin
        if (clr_cnt_q == CLR_LAST) state_d = ST_EMPTY;
        else                       clr_cnt_d = clr_cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
      default: begin
        state_d   = ST_CLR;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign state_o = state_q;
  assign clear_o = (state_q == ST_CLR);

endmodule

`default_nettype wire

// File: rtl/l2_temp_pingpong_ctrl.sv
// +----------------------------------------------------------------------------+
// | l2_temp_pingpong_ctrl : shares two layer-2 temp banks between the layer-2 |
// | producer and the layer-3 consumer.          Revision 1.0                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module l2_temp_pingpong_ctrl
  import l2_temp_pingpong_ctrl_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEFAULT,
  parameter int AW           = AW_DEFAULT,
  parameter int CLEAR_CYCLES = 1
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          img_valid_i,
  output logic          img_ready_o,
  output logic          l2_start_o,
  input  logic          l2_wr_en_i,
  input  logic [AW-1:0] l2_wr_addr_i,
  input  logic          l3_ready_i,
  output logic          l3_start_o,
  input  logic          l3_rd_en_i,
  input  logic [AW-1:0] l3_rd_addr_i,
  input  logic          l3_done_i,
  output logic [1:0]    bank_wr_en_o,
  output logic [1:0]    bank_rd_en_o,
  output logic [1:0]    bank_clear_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [AW-1:0] rd_addr_o,
  output logic          rd_sel_o,
  output logic          err_o
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

  bank_state_t bank_state [2];
  logic [1:0]  fill_start, fill_done, drain_start, drain_done;

  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW:0]   wr_cnt_q, wr_cnt_d;
  logic          l2_start_q, l2_start_d;
  logic          l3_start_q, l3_start_d;
  logic [1:0]    bank_wr_en_q, bank_wr_en_d;
  logic [1:0]    bank_rd_en_q, bank_rd_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_sel_q, rd_sel_d;
  logic          err_q, err_d;

  logic        fill_any, drain_any;
  logic        grant_l2, grant_l3;
  logic        wr_accept, rd_accept, done_accept;
  logic        last_wr;
  logic [AW:0] wr_cnt_inc;

  assign fill_any  = (bank_state[0] == ST_FILL)  || (bank_state[1] == ST_FILL);
  assign drain_any = (bank_state[0] == ST_DRAIN) || (bank_state[1] == ST_DRAIN);

  // Grants look only at registered bank state, so a bank changing state this
  // cycle becomes eligible next cycle.
  assign grant_l2 = img_valid_i && (bank_state[wr_bank_q] == ST_EMPTY) && !fill_any;
  assign grant_l3 = l3_ready_i  && (bank_state[rd_bank_q] == ST_FULL)  && !drain_any;

  assign wr_accept   = l2_wr_en_i && (bank_state[wr_bank_q] == ST_FILL);
  assign rd_accept   = l3_rd_en_i && (bank_state[rd_bank_q] == ST_DRAIN);
  assign done_accept = l3_done_i  && (bank_state[rd_bank_q] == ST_DRAIN);

  assign wr_cnt_inc = wr_cnt_q + CNT_ONE;
  assign last_wr    = wr_accept && (wr_cnt_inc == CNT_FULL);

  assign img_ready_o = (bank_state[wr_bank_q] == ST_EMPTY) && !fill_any;

  genvar b;
  generate
    for (b = 0; b < 2; b++) begin : g_bank
      assign fill_start[b]  = grant_l2    && (wr_bank_q == 1'(b));
      assign fill_done[b]   = last_wr     && (wr_bank_q == 1'(b));
      assign drain_start[b] = grant_l3    && (rd_bank_q == 1'(b));
      assign drain_done[b]  = done_accept && (rd_bank_q == 1'(b));

      temp_bank_fsm #(
        .CLEAR_CYCLES (CLEAR_CYCLES)
      ) u_bank_fsm (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .fill_start_i  (fill_start[b]),
        .fill_done_i   (fill_done[b]),
        .drain_start_i (drain_start[b]),
        .drain_done_i  (drain_done[b]),
        .state_o       (bank_state[b]),
        .clear_o       (bank_clear_o[b])
      );
    end
  endgenerate

  always_comb begin
    l2_start_d   = grant_l2;
    l3_start_d   = grant_l3;
    rd_sel_d     = grant_l3 ? rd_bank_q : rd_sel_q;
    bank_wr_en_d = wr_accept ? (2'b01 << wr_bank_q) : 2'b00;
    bank_rd_en_d = rd_accept ? (2'b01 << rd_bank_q) : 2'b00;
    wr_addr_d    = l2_wr_addr_i;
    rd_addr_d    = l3_rd_addr_i;
    wr_bank_d    = wr_bank_q ^ last_wr;
    rd_bank_d    = rd_bank_q ^ done_accept;

    wr_cnt_d = wr_cnt_q;
    if (grant_l2)       wr_cnt_d = '0;
    else if (wr_accept) wr_cnt_d = wr_cnt_inc;

    err_d = err_q
          | (l2_wr_en_i && !wr_accept)
          | (l3_rd_en_i && !rd_accept)
          | (l3_done_i  && !done_accept);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_cnt_q     <= '0;
      l2_start_q   <= 1'b0;
      l3_start_q   <= 1'b0;
      bank_wr_en_q <= 2'b00;
      bank_rd_en_q <= 2'b00;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      rd_sel_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_cnt_q     <= wr_cnt_d;
      l2_start_q   <= l2_start_d;
      l3_start_q   <= l3_start_d;
      bank_wr_en_q <= bank_wr_en_d;
      bank_rd_en_q <= bank_rd_en_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      rd_sel_q     <= rd_sel_d;
      err_q        <= err_d;
    end
  end

  assign l2_start_o   = l2_start_q;
  assign l3_start_o   = l3_start_q;
  assign bank_wr_en_o = bank_wr_en_q;
  assign bank_rd_en_o = bank_rd_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign rd_addr_o    = rd_addr_q;
  assign rd_sel_o     = rd_sel_q;
  assign err_o        = err_q;

endmodule

`default_nettype wire
